// File: rtl/bus_memory_slave_if.sv
// Bus between a transaction master and the word-addressed memory slave.
interface bus_memory_slave_if;
    logic        begin_transactionIN;
    logic [31:0] address_dataIN;
    logic [3:0]  byte_enableIN;
    logic [7:0]  burst_sizeIN;
    logic        read_n_writeIN;
    logic        data_validIN;
    logic        end_transactionIN;
    logic        busyIN;
    logic [31:0] address_dataOUT;
    logic        data_validOUT;
    logic        end_transactionOUT;
    logic        busyOUT;
    logic        errorOUT;

    modport slave (
        input  begin_transactionIN, address_dataIN, byte_enableIN, burst_sizeIN,
               read_n_writeIN, data_validIN, end_transactionIN, busyIN,
        output address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
    );

    modport master (
        output begin_transactionIN, address_dataIN, byte_enableIN, burst_sizeIN,
               read_n_writeIN, data_validIN, end_transactionIN, busyIN,
        input  address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
    );
endinterface

// File: rtl/bus_memory_slave.sv
// Burst-capable memory slave: claims an aligned address region and serves
// byte-enabled write bursts and latency-configurable read bursts.
module bus_memory_slave #(
    parameter logic [31:0] BASE_ADDRESS      = 32'h5555_0000,
    parameter int          ADDR_BITS         = 8,
    parameter int          READ_LATENCY      = 1,
    parameter int          WRITE_BUSY_CYCLES = 0
) (
    input logic              system_clock,
    input logic              system_reset,
    bus_memory_slave_if.slave bus
);

    localparam int MEM_WORDS = 2 ** ADDR_BITS;
    localparam int SPAN_W    = ADDR_BITS + 9;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_READ_WAIT = 3'd2;
    localparam logic [2:0] S_READ      = 3'd3;
    localparam logic [2:0] S_END       = 3'd4;
    localparam logic [2:0] S_ERROR     = 3'd5;

    logic [31:0]          mem [MEM_WORDS];
    logic [2:0]           state;
    logic [ADDR_BITS-1:0] index;
    logic [7:0]           burst;
    logic [3:0]           byte_en;
    logic [8:0]           beat_count;
    logic [3:0]           wait_count;
    logic [3:0]           busy_count;

    logic [ADDR_BITS-1:0] req_index;
    logic [ADDR_BITS-1:0] next_index;
    logic [SPAN_W-1:0]    span;
    logic                 claim;
    logic                 overflow;
    logic                 write_beat;
    logic                 last_read;
    logic                 unused_addr_lsbs;

    assign req_index  = bus.address_dataIN[ADDR_BITS+1:2];
    assign next_index = index + 1'b1;
    assign claim      = bus.begin_transactionIN &&
                        (bus.address_dataIN[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2]);
    // Last word touched must stay inside the region; the burst never wraps.
    assign span       = SPAN_W'(req_index) + SPAN_W'(bus.burst_sizeIN);
    assign overflow   = span > SPAN_W'(MEM_WORDS - 1);
    assign write_beat = (state == S_WRITE) && bus.data_validIN && !bus.busyOUT &&
                        (beat_count <= {1'b0, burst});
    assign last_read  = beat_count == {1'b0, burst};
    assign unused_addr_lsbs = ^bus.address_dataIN[1:0];

    // Memory contents survive reset.
    always_ff @(posedge system_clock) begin
        if (write_beat && !system_reset) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[index][8*b +: 8] <= bus.address_dataIN[8*b +: 8];
            end
        end
    end

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            state                  <= S_IDLE;
            index                  <= '0;
            burst                  <= '0;
            byte_en                <= '0;
            beat_count             <= '0;
            wait_count             <= '0;
            busy_count             <= '0;
            bus.address_dataOUT    <= '0;
            bus.data_validOUT      <= 1'b0;
            bus.end_transactionOUT <= 1'b0;
            bus.busyOUT            <= 1'b0;
            bus.errorOUT           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.address_dataOUT    <= '0;
                    bus.data_validOUT      <= 1'b0;
                    bus.end_transactionOUT <= 1'b0;
                    bus.busyOUT            <= 1'b0;
                    bus.errorOUT           <= 1'b0;
                    if (claim) begin
                        index      <= req_index;
                        burst      <= bus.burst_sizeIN;
                        byte_en    <= bus.byte_enableIN;
                        beat_count <= '0;
                        if (overflow) begin
                            state                  <= S_ERROR;
                            bus.errorOUT           <= 1'b1;
                            bus.end_transactionOUT <= 1'b1;
                        end else if (bus.read_n_writeIN) begin
                            if (READ_LATENCY == 0) begin
                                state               <= S_READ;
                                bus.data_validOUT   <= 1'b1;
                                bus.address_dataOUT <= mem[req_index];
                            end else begin
                                state      <= S_READ_WAIT;
                                wait_count <= 4'(READ_LATENCY - 1);
                            end
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.busyOUT) begin
                        busy_count <= busy_count - 1'b1;
                        if (busy_count == 4'd1) bus.busyOUT <= 1'b0;
                    end
                    if (write_beat) begin
                        index      <= next_index;
                        beat_count <= beat_count + 1'b1;
                        if (WRITE_BUSY_CYCLES > 0) begin
                            bus.busyOUT <= 1'b1;
                            busy_count  <= 4'(WRITE_BUSY_CYCLES);
                        end
                    end
                    // Termination wins over a busy window still in progress.
                    if (bus.end_transactionIN) begin
                        state       <= S_IDLE;
                        bus.busyOUT <= 1'b0;
                        busy_count  <= '0;
                    end
                end
                S_READ_WAIT: begin
                    if (wait_count == 4'd0) begin
                        state               <= S_READ;
                        bus.data_validOUT   <= 1'b1;
                        bus.address_dataOUT <= mem[index];
                    end else begin
                        wait_count <= wait_count - 1'b1;
                    end
                end
                S_READ: begin
                    if (!bus.busyIN) begin
                        if (last_read) begin
                            state                  <= S_END;
                            bus.data_validOUT      <= 1'b0;
                            bus.address_dataOUT    <= '0;
                            bus.end_transactionOUT <= 1'b1;
                        end else begin
                            index               <= next_index;
                            beat_count          <= beat_count + 1'b1;
                            bus.address_dataOUT <= mem[next_index];
                        end
                    end
                end
                S_END, S_ERROR: begin
                    state                  <= S_IDLE;
                    bus.end_transactionOUT <= 1'b0;
                    bus.errorOUT           <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_memory_slave.md
BUS_MEMORY_SLAVE -- requirements
Module: bus_memory_slave

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h5555_0000, region base; aligned to region size.
REQ-002 SHALL have parameter ADDR_BITS, default 8, log2 of word count (MEM_WORDS = 2^ADDR_BITS).
REQ-003 SHALL have parameter READ_LATENCY, default 1, idle cycles between begin and first read beat (0..15).
REQ-004 SHALL have parameter WRITE_BUSY_CYCLES, default 0, busyOUT cycles inserted after each accepted write beat (0..15).
REQ-005 SHALL use one clock and a synchronous, active-high reset: system_clock in 1, rising-edge clock; system_reset in 1.
REQ-006 SHALL have ports: begin_transactionIN in 1, start pulse; address_dataIN in 32, address on begin, write data on beats; byte_enableIN in 4, per-byte write enables; burst_sizeIN in 8, beats minus one; read_n_writeIN in 1, 1=read; data_validIN in 1, write beat valid; end_transactionIN in 1, master ends write; busyIN in 1, master stalls read beat.
REQ-007 SHALL have outputs: address_dataOUT out 32, read data; data_validOUT out 1, read beat valid; end_transactionOUT out 1, end of read/error; busyOUT out 1, slave stalls write beat; errorOUT out 1, error pulse. All registered.

Function
REQ-008 SHALL claim a transaction only when begin_transactionIN=1 in IDLE and address_dataIN[31:ADDR_BITS+2]==BASE_ADDRESS[31:ADDR_BITS+2]; otherwise it stays IDLE with all outputs 0.
REQ-009 SHALL latch word index = address_dataIN[ADDR_BITS+1:2], burst_sizeIN, byte_enableIN, read_n_writeIN on the claiming cycle; address bits [1:0] ignored.
REQ-010 SHALL, if word index + burst_sizeIN > MEM_WORDS-1, enter ERROR: errorOUT=1 and end_transactionOUT=1 for exactly one cycle the cycle after begin, no memory access, then IDLE.
REQ-011 SHALL implement states IDLE, WRITE, READ_WAIT, READ, END, ERROR.
REQ-012 SHALL, in WRITE, accept a beat on a cycle with data_validIN=1 and busyOUT=0; write byte i of address_dataIN into byte i of mem[index] iff latched byte_enable[i]=1; then increment index.
REQ-013 SHALL, when WRITE_BUSY_CYCLES=N>0, assert busyOUT for exactly N cycles starting the cycle after each accepted beat; data_validIN during busyOUT=1 is not accepted.
REQ-014 SHALL ignore write beats beyond burst_size+1 accepted beats (no memory change, no wrap).
REQ-015 SHALL leave WRITE for IDLE on the cycle end_transactionIN=1, regardless of beat count (early termination keeps beats already written); busyOUT cleared the following cycle.
REQ-016 SHALL, in READ_WAIT, count READ_LATENCY cycles then enter READ; READ_LATENCY=0 enters READ directly the cycle after begin.
REQ-017 SHALL, in READ, drive data_validOUT=1 with address_dataOUT=mem[index] (full word, byte enables ignored); a beat is consumed when data_validOUT=1 and busyIN=0; on consumption index increments and next word is presented the next cycle.
REQ-018 SHALL hold address_dataOUT and data_validOUT unchanged while busyIN=1.
REQ-019 SHALL, after the (burst_size+1)th consumed beat, enter END: data_validOUT=0, end_transactionOUT=1 for one cycle, address_dataOUT=0, then IDLE.
REQ-020 SHALL ignore begin_transactionIN in every state other than IDLE.
REQ-021 SHALL drive address_dataOUT=0 whenever data_validOUT=0.

Reset
REQ-022 SHALL, on system_reset=1 at a clock edge, enter IDLE and drive address_dataOUT=0, data_validOUT=0, end_transactionOUT=0, busyOUT=0, errorOUT=0, clearing all counters.
REQ-023 SHALL abort any in-progress transaction on reset mid-operation without emitting end_transactionOUT; memory contents are not cleared by reset.
REQ-024 SHALL accept a new begin_transactionIN on the first cycle after system_reset deasserts.

Verification
REQ-025 Write burst: begin addr 32'h5555_0010, burst 3, be 4'hF, beats AAAAAAAA/BBBBBBBB/CCCCCCCC/DDDDDDDD, end -> mem[4..7] hold those words; busyOUT stays 0.
REQ-026 Byte-enable + busy: WRITE_BUSY_CYCLES=2, mem[0]=DEADBEEF, write 12345678 be 4'b0101 to 32'h5555_0000 -> mem[0]=DE34BE78; busyOUT high 2 cycles after beat; beat held during busy written once.
REQ-027 Read burst: READ_LATENCY=1, read addr 32'h5555_0010 burst 3, busyIN=1 on second beat for 3 cycles -> data AAAAAAAA,BBBBBBBB(held 4 cycles),CCCCCCCC,DDDDDDDD, then single end_transactionOUT pulse.
REQ-028 Boundary: read addr 32'h5555_03FC burst 0 -> one beat mem[255], end; burst 1 at same addr -> errorOUT+end_transactionOUT one cycle, no data_validOUT.
REQ-029 Address decode: begin addr 32'hA000_0000 -> no response, all outputs 0; begin during READ ignored.
REQ-030 Reset mid-read after 2 of 4 beats -> next cycle all outputs 0, no end pulse; subsequent read of mem[4] returns AAAAAAAA.
